// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the accumulator CPU: opcodes (ALU encodings),
// controller state encoding and the controller strobe bundle.
package cpu_defs_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] HLT  = 3'b000;
   localparam logic [OP_W-1:0] SKZ  = 3'b001;
   localparam logic [OP_W-1:0] ADD  = 3'b010;
   localparam logic [OP_W-1:0] ANDD = 3'b011;
   localparam logic [OP_W-1:0] XORR = 3'b100;
   localparam logic [OP_W-1:0] LDA  = 3'b101;
   localparam logic [OP_W-1:0] STO  = 3'b110;
   localparam logic [OP_W-1:0] JMP  = 3'b111;

   typedef enum logic [3:0] {
      S0     = 4'd0,
      S1     = 4'd1,
      S2     = 4'd2,
      S3     = 4'd3,
      S4     = 4'd4,
      S5     = 4'd5,
      S6     = 4'd6,
      S7     = 4'd7,
      HALTED = 4'd8
   } state_e;

   typedef struct packed {
      logic inc_pc;
      logic load_pc;
      logic load_ir;
      logic rd;
      logic wr;
      logic datactl_ena;
      logic alu_ena;
      logic load_acc;
      logic halt;
   } strobe_t;

   // Opcodes that read an operand from memory and push it through the ALU.
   function automatic logic is_data_op(input logic [OP_W-1:0] op);
      return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
   endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decoder: (state, latched opcode, latched zero) -> strobes.
// No enable or reset gating here; the FSM top applies both.
module cpu_ctrl_decode
   import cpu_defs_pkg::*;
(
   input  state_e              state,
   input  logic [OP_W-1:0]     op_q,
   input  logic                zero_q,
   output strobe_t             strb
);

   logic data_op;

   always_comb begin
      strb    = '0;
      data_op = is_data_op(op_q);
      case (state)
         S0, S1: begin
            strb.rd      = 1'b1;
            strb.load_ir = 1'b1;
            strb.inc_pc  = 1'b1;
         end
         S4: begin
            strb.rd          = data_op;
            strb.datactl_ena = (op_q == STO);
            strb.load_pc     = (op_q == JMP);
            strb.inc_pc      = (op_q == SKZ) && zero_q;
         end
         S5: begin
            strb.rd          = data_op;
            strb.alu_ena     = data_op;
            strb.datactl_ena = (op_q == STO);
            strb.wr          = (op_q == STO);
            strb.load_pc     = (op_q == JMP);
            strb.inc_pc      = (op_q == SKZ) && zero_q;
         end
         S6: begin
            strb.load_acc    = data_op;
            // Keep the store data on the bus one cycle past wr for hold time.
            strb.datactl_ena = (op_q == STO);
         end
         HALTED: strb.halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction-sequencing controller: 8-cycle machine per instruction, HLT parks in HALTED.
// Holds state, latched opcode and zero flag; strobes gated by ena and forced low in rst.
module cpu_ctrl_fsm #(
   parameter int OP_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   output logic            inc_pc,
   output logic            load_pc,
   output logic            load_ir,
   output logic            rd,
   output logic            wr,
   output logic            datactl_ena,
   output logic            alu_ena,
   output logic            load_acc,
   output logic            halt
);
   import cpu_defs_pkg::*;

   state_e          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic            zero_q, zero_d;
   strobe_t         dec_strb;
   strobe_t         out_strb;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      zero_d  = zero_q;
      if (ena) begin
         case (state_q)
            S0: state_d = S1;
            S1: state_d = S2;
            S2: begin
               state_d = S3;
               op_d    = opcode;
               zero_d  = zero;
            end
            S3: state_d = (op_q == HLT) ? HALTED : S4;
            S4: state_d = S5;
            S5: state_d = S6;
            S6: state_d = S7;
            S7: state_d = S0;
            HALTED: state_d = HALTED;
            default: state_d = S0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S0;
         op_q    <= HLT;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         zero_q  <= zero_d;
      end
   end

   cpu_ctrl_decode u_decode (
      .state  (state_q),
      .op_q   (op_q),
      .zero_q (zero_q),
      .strb   (dec_strb)
   );

   // halt follows the state alone; every other strobe also needs ena.
   always_comb begin
      out_strb = dec_strb;
      if (!ena) begin
         out_strb      = '0;
         out_strb.halt = dec_strb.halt;
      end
      if (rst) out_strb = '0;
   end

   assign inc_pc      = out_strb.inc_pc;
   assign load_pc     = out_strb.load_pc;
   assign load_ir     = out_strb.load_ir;
   assign rd          = out_strb.rd;
   assign wr          = out_strb.wr;
   assign datactl_ena = out_strb.datactl_ena;
   assign alu_ena     = out_strb.alu_ena;
   assign load_acc    = out_strb.load_acc;
   assign halt        = out_strb.halt;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed test-plan sequences plus randomized run against an instruction-level model.
module tb_cpu_ctrl_fsm;

   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ANDD = 3'b011;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic       zero = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       inc_pc, load_pc, load_ir, rd, wr, datactl_ena, alu_ena, load_acc, halt;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int c_inc, c_ldpc, c_alu, c_acc, c_wr, c_rd, c_halt;

   // Model: cycle index within the current instruction, plus halted flag and latched decode.
   int         m_phase = 0;
   bit         m_halt  = 1'b0;
   logic [2:0] m_op    = OP_HLT;
   bit         m_zero  = 1'b0;

   cpu_ctrl_fsm #(.OP_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .opcode      (opcode),
      .zero        (zero),
      .inc_pc      (inc_pc),
      .load_pc     (load_pc),
      .load_ir     (load_ir),
      .rd          (rd),
      .wr          (wr),
      .datactl_ena (datactl_ena),
      .alu_ena     (alu_ena),
      .load_acc    (load_acc),
      .halt        (halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Order: {inc_pc, load_pc, load_ir, rd, wr, datactl_ena, alu_ena, load_acc, halt}
   function automatic logic [8:0] expect_outs(input bit r, input bit e);
      bit data = (m_op == OP_ADD) || (m_op == OP_ANDD) || (m_op == OP_XORR) || (m_op == OP_LDA);
      bit sto  = (m_op == OP_STO);
      bit ip = 0, lp = 0, li = 0, rdx = 0, wrx = 0, dc = 0, al = 0, la = 0;
      if (r) return 9'b0;
      if (m_halt) return 9'b0_0000_0001;
      if (!e) return 9'b0;
      if (m_phase < 2) begin
         rdx = 1; li = 1; ip = 1;
      end else if (m_phase == 4 || m_phase == 5) begin
         rdx = data;
         al  = data && (m_phase == 5);
         dc  = sto;
         wrx = sto && (m_phase == 5);
         lp  = (m_op == OP_JMP);
         ip  = (m_op == OP_SKZ) && m_zero;
      end else if (m_phase == 6) begin
         la = data;
         dc = sto;
      end
      return {ip, lp, li, rdx, wrx, dc, al, la, 1'b0};
   endfunction

   task automatic clr();
      c_inc = 0; c_ldpc = 0; c_alu = 0; c_acc = 0; c_wr = 0; c_rd = 0; c_halt = 0;
   endtask

   task automatic step(input bit r, input bit e, input logic [2:0] op, input bit z);
      logic [8:0] obs;
      @(negedge clk);
      rst = r; ena = e; opcode = op; zero = z;
      #1;
      obs = {inc_pc, load_pc, load_ir, rd, wr, datactl_ena, alu_ena, load_acc, halt};
      check($sformatf("outs@%0d", cyc), 32'(obs), 32'(expect_outs(r, e)));
      check("rd_wr_excl", 32'(rd & wr), 32'd0);
      check("pc_excl", 32'(load_pc & inc_pc), 32'd0);
      check("load_excl", 32'($countones({load_ir, load_acc, load_pc}) <= 1), 32'd1);
      c_inc  += int'(inc_pc);
      c_ldpc += int'(load_pc);
      c_alu  += int'(alu_ena);
      c_acc  += int'(load_acc);
      c_wr   += int'(wr);
      c_rd   += int'(rd);
      c_halt += int'(halt);
      @(posedge clk);
      if (r) begin
         m_phase = 0; m_halt = 0; m_op = OP_HLT; m_zero = 0;
      end else if (!m_halt && e) begin
         if (m_phase == 2) begin
            m_op = op; m_zero = z;
         end
         if (m_phase == 3 && m_op == OP_HLT) m_halt = 1;
         else m_phase = (m_phase + 1) % 8;
      end
      cyc++;
   endtask

   initial begin
      clr();
      step(1, 0, OP_LDA, 0);
      step(1, 1, OP_LDA, 1);

      clr();
      repeat (8) step(0, 1, OP_LDA, 0);
      check("lda_alu", c_alu, 1);
      check("lda_acc", c_acc, 1);
      check("lda_rd", c_rd, 4);
      check("lda_inc", c_inc, 2);

      clr();
      repeat (8) step(0, 1, OP_STO, 1);
      check("sto_wr", c_wr, 1);
      check("sto_rd", c_rd, 2);
      check("sto_alu", c_alu, 0);

      clr();
      repeat (8) step(0, 1, OP_SKZ, 1);
      check("skz_z1_inc", c_inc, 4);
      clr();
      for (int i = 0; i < 8; i++) step(0, 1, OP_SKZ, i <= 2);
      check("skz_z10_inc", c_inc, 4);
      clr();
      repeat (8) step(0, 1, OP_SKZ, 0);
      check("skz_z0_inc", c_inc, 2);

      clr();
      repeat (8) step(0, 1, OP_JMP, 0);
      check("jmp_ldpc", c_ldpc, 2);
      check("jmp_inc", c_inc, 2);
      check("jmp_alu", c_alu, 0);

      clr();
      repeat (4) step(0, 1, OP_HLT, 0);
      check("hlt_early", c_halt, 0);
      repeat (20) step(0, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)));
      check("hlt_halt", c_halt, 20);
      check("hlt_rd", c_rd, 2);
      step(1, 1, OP_ADD, 0);

      clr();
      repeat (5) step(0, 1, OP_ADD, 0);
      repeat (3) step(0, 0, OP_ADD, 0);
      check("stall_alu", c_alu, 0);
      repeat (3) step(0, 1, OP_ADD, 0);
      check("resume_alu", c_alu, 1);
      check("resume_acc", c_acc, 1);

      repeat (5) step(0, 1, OP_ADD, 0);
      clr();
      step(1, 1, OP_ADD, 0);
      step(0, 1, OP_STO, 0);
      step(0, 1, OP_STO, 0);
      check("rst_mid_acc", c_acc, 0);
      check("rst_mid_wr", c_wr, 0);
      check("rst_mid_fetch", c_inc, 2);
      repeat (6) step(0, 1, OP_ADD, 0);

      repeat (3000) begin
         step($urandom_range(63) == 0, $urandom_range(7) != 0,
              3'($urandom_range(7)), 1'($urandom_range(1)));
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
